// File: rtl/sr_pkg.sv
// Shared constants for the SimpleRISC system: opcodes, sub-ops, condition and
// shift codes, FSM state type and the memory-mapped I/O addresses.
package sr_pkg;

   localparam logic [2:0] OPC_BR   = 3'b001;
   localparam logic [2:0] OPC_BL   = 3'b010;
   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] OP_MOV_REG = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;
   localparam logic [1:0] OP_MEM     = 2'b00;
   localparam logic [1:0] OP_BX      = 2'b00;
   localparam logic [1:0] OP_BLX     = 2'b10;
   localparam logic [1:0] OP_BL      = 2'b11;

   localparam logic [2:0] COND_AL = 3'b000;
   localparam logic [2:0] COND_EQ = 3'b001;
   localparam logic [2:0] COND_NE = 3'b010;
   localparam logic [2:0] COND_LT = 3'b011;
   localparam logic [2:0] COND_LE = 3'b100;

   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;

   localparam logic [8:0] ADDR_LED = 9'h100;
   localparam logic [8:0] ADDR_SW  = 9'h140;

   typedef enum logic [1:0] {
      S_FETCH = 2'b00,
      S_EX0   = 2'b01,
      S_EX1   = 2'b10,
      S_HALT  = 2'b11
   } state_t;

   function automatic logic [15:0] shift16(input logic [15:0] v, input logic [1:0] sh);
      case (sh)
         SH_LSL:  return {v[14:0], 1'b0};
         SH_LSR:  return {1'b0, v[15:1]};
         SH_ASR:  return {v[15], v[15:1]};
         default: return v;
      endcase
   endfunction

endpackage

// File: rtl/sr_mem_if.sv
// Bus between the CPU core and the memory/I-O block: two combinational
// instruction read ports plus one data port with combinational read.
interface sr_mem_if;
   logic [8:0]  pc;
   logic [15:0] p0_ir;
   logic [15:0] p1_ir;
   logic [8:0]  d_addr;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   logic        d_we;

   modport master (
      output pc, d_addr, d_wdata, d_we,
      input  p0_ir, p1_ir, d_rdata
   );

   modport slave (
      input  pc, d_addr, d_wdata, d_we,
      output p0_ir, p1_ir, d_rdata
   );
endinterface

// File: rtl/cpu.sv
// SimpleRISC core executing instruction pairs fetched as {mem[PC], mem[PC+1]}.
// Holds the FSM, register file, shifter, ALU and branch unit.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_FETCH | latch IR0 <= mem[PC], IR1 <= mem[PC+1]
//   S_EX0   | execute IR0; a taken branch skips IR1 and refetches at target
//   S_EX1   | execute IR1; PC <= PC+2 unless the instruction branched
//   S_HALT  | stopped; only reset leaves this state
module cpu
   import sr_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   sr_mem_if.master  bus,
   output logic      fetch_next,
   output logic      halted
);

   state_t      state, state_nx;
   logic [8:0]  PC, pc_nx;
   logic [15:0] p0_IR_in, p1_IR_in;
   logic [15:0] ir0, ir1;
   logic [15:0] regs [0:7];
   logic        flag_z, flag_n, flag_v;

   logic [15:0] ir;
   logic [8:0]  slot_pc, slot_nx;
   logic [2:0]  opcode;
   logic [1:0]  op, sh;
   logic [2:0]  rn, rd, rm, cond;
   logic [15:0] rn_val, rd_val, rm_val, shv, sum, diff, imm8_sx;
   logic [8:0]  br_target;
   logic        exec, cond_ok, diff_v;

   logic        reg_we, flags_we, d_we, take, halt_now;
   logic [2:0]  reg_wa;
   logic [15:0] reg_wd;
   logic [8:0]  target;

   assign p0_IR_in = bus.p0_ir;
   assign p1_IR_in = bus.p1_ir;
   assign bus.pc   = PC;

   assign exec    = (state == S_EX0) || (state == S_EX1);
   assign ir      = (state == S_EX1) ? ir1 : ir0;
   assign slot_pc = (state == S_EX1) ? PC + 9'd1 : PC;
   assign slot_nx = slot_pc + 9'd1;

   assign opcode = ir[15:13];
   assign op     = ir[12:11];
   assign rn     = ir[10:8];
   assign cond   = ir[10:8];
   assign rd     = ir[7:5];
   assign sh     = ir[4:3];
   assign rm     = ir[2:0];

   assign rn_val  = regs[rn];
   assign rd_val  = regs[rd];
   assign rm_val  = regs[rm];
   assign shv     = shift16(rm_val, sh);
   assign sum     = rn_val + shv;
   assign diff    = rn_val - shv;
   assign diff_v  = (rn_val[15] != shv[15]) && (diff[15] != rn_val[15]);
   assign imm8_sx = {{8{ir[7]}}, ir[7:0]};

   // Branch math is relative to the slot's own address, not the pair base.
   assign br_target = slot_nx + {ir[7], ir[7:0]};

   assign bus.d_addr  = rn_val[8:0] + {{4{ir[4]}}, ir[4:0]};
   assign bus.d_wdata = rd_val;
   assign bus.d_we    = d_we;

   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         COND_AL: cond_ok = 1'b1;
         COND_EQ: cond_ok = flag_z;
         COND_NE: cond_ok = !flag_z;
         COND_LT: cond_ok = (flag_n != flag_v);
         COND_LE: cond_ok = (flag_n != flag_v) || flag_z;
         default: cond_ok = 1'b0;
      endcase
   end

   always_comb begin
      reg_we   = 1'b0;
      reg_wa   = rd;
      reg_wd   = shv;
      flags_we = 1'b0;
      d_we     = 1'b0;
      take     = 1'b0;
      target   = br_target;
      halt_now = 1'b0;
      if (exec) begin
         case (opcode)
            OPC_MOV: begin
               if (op == OP_MOV_IMM) begin
                  reg_we = 1'b1;
                  reg_wa = rn;
                  reg_wd = imm8_sx;
               end else if (op == OP_MOV_REG) begin
                  reg_we = 1'b1;
               end
            end
            OPC_ALU: begin
               case (op)
                  OP_ADD: begin reg_we = 1'b1; reg_wd = sum;          end
                  OP_CMP: flags_we = 1'b1;
                  OP_AND: begin reg_we = 1'b1; reg_wd = rn_val & shv; end
                  OP_MVN: begin reg_we = 1'b1; reg_wd = ~shv;         end
                  default: ;
               endcase
            end
            OPC_LDR: begin
               if (op == OP_MEM) begin
                  reg_we = 1'b1;
                  reg_wd = bus.d_rdata;
               end
            end
            OPC_STR: d_we = (op == OP_MEM);
            OPC_BR:  take = cond_ok;
            OPC_BL: begin
               case (op)
                  OP_BL: begin
                     reg_we = 1'b1;
                     reg_wa = 3'd7;
                     reg_wd = {7'd0, slot_nx};
                     take   = 1'b1;
                  end
                  OP_BX: begin
                     take   = 1'b1;
                     target = rd_val[8:0];
                  end
                  OP_BLX: begin
                     reg_we = 1'b1;
                     reg_wa = 3'd7;
                     reg_wd = {7'd0, slot_nx};
                     take   = 1'b1;
                     target = rd_val[8:0];
                  end
                  default: ;
               endcase
            end
            OPC_HALT: halt_now = 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx   = state;
      pc_nx      = PC;
      fetch_next = 1'b0;
      case (state)
         S_FETCH: state_nx = S_EX0;
         S_EX0: begin
            if (halt_now) begin
               state_nx = S_HALT;
            end else if (take) begin
               state_nx   = S_FETCH;
               pc_nx      = target;
               fetch_next = 1'b1;
            end else begin
               state_nx = S_EX1;
            end
         end
         S_EX1: begin
            if (halt_now) begin
               state_nx = S_HALT;
               pc_nx    = slot_pc;
            end else begin
               state_nx   = S_FETCH;
               fetch_next = 1'b1;
               pc_nx      = take ? target : PC + 9'd2;
            end
         end
         default: state_nx = S_HALT;
      endcase
   end

   assign halted = (state == S_HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_FETCH;
         PC     <= 9'd0;
         ir0    <= 16'h0000;
         ir1    <= 16'h0000;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_v <= 1'b0;
         for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
      end else begin
         state <= state_nx;
         PC    <= pc_nx;
         if (state == S_FETCH) begin
            ir0 <= p0_IR_in;
            ir1 <= p1_IR_in;
         end
         if (reg_we) regs[reg_wa] <= reg_wd;
         if (flags_we) begin
            flag_z <= (diff == 16'h0000);
            flag_n <= diff[15];
            flag_v <= diff_v;
         end
      end
   end

endmodule

// File: rtl/lab7bonus_top_sys.sv
// FPGA top: SimpleRISC core, 256x16 RAM, LED register and switch input.
// RAM contents come from the programming image and survive KEY[1] reset.
module lab7bonus_top_sys
   import sr_pkg::*;
(
   input  logic       CLOCK_50,
   input  logic [3:0] KEY,
   input  logic [9:0] SW,
   output logic [9:0] LEDR,
   output logic [6:0] HEX0,
   output logic [6:0] HEX1,
   output logic [6:0] HEX2,
   output logic [6:0] HEX3,
   output logic [6:0] HEX4,
   output logic [6:0] HEX5
);

   sr_mem_if    bus ();
   logic        rst_n;
   logic        fetch_next, halted;
   logic [7:0]  led_q;
   logic [8:0]  pc1;
   logic [15:0] mem [0:255];
   logic        unused_inputs;

   assign rst_n         = KEY[1];
   assign unused_inputs = ^{KEY[3:2], KEY[0], SW[9:8], fetch_next};

   cpu CPU (
      .clk        (CLOCK_50),
      .rst_n      (rst_n),
      .bus        (bus),
      .fetch_next (fetch_next),
      .halted     (halted)
   );

   // Addresses at or above 0x100 hold no RAM; instruction reads there see NOP.
   assign pc1       = bus.pc + 9'd1;
   assign bus.p0_ir = bus.pc[8] ? 16'h0000 : mem[bus.pc[7:0]];
   assign bus.p1_ir = pc1[8]    ? 16'h0000 : mem[pc1[7:0]];

   always_comb begin
      bus.d_rdata = 16'h0000;
      if (!bus.d_addr[8])
         bus.d_rdata = mem[bus.d_addr[7:0]];
      else if (bus.d_addr == ADDR_SW)
         bus.d_rdata = {8'h00, SW[7:0]};
   end

   always_ff @(posedge CLOCK_50) begin
      if (bus.d_we && !bus.d_addr[8]) mem[bus.d_addr[7:0]] <= bus.d_wdata;
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n)
         led_q <= 8'h00;
      else if (bus.d_we && bus.d_addr == ADDR_LED)
         led_q <= bus.d_wdata[7:0];
   end

   assign LEDR = {1'b0, halted, led_q};
   assign HEX0 = 7'h7F;
   assign HEX1 = 7'h7F;
   assign HEX2 = 7'h7F;
   assign HEX3 = 7'h7F;
   assign HEX4 = 7'h7F;
   assign HEX5 = 7'h7F;

endmodule

// File: tb/tb_lab7bonus_top_sys.sv
// Directed bench for lab7bonus_top_sys: small hand-assembled programs loaded
// into RAM, with expected register/PC/LED values worked out by hand.
module tb_lab7bonus_top_sys;
   import sr_pkg::*;

   logic       CLOCK_50 = 1'b0;
   logic [3:0] KEY;
   logic [9:0] SW;
   logic [9:0] LEDR;
   logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

   int total = 0;
   int bad = 0;
   int fn_count = 0;
   int fn_base = 0;

   sr_mem_if mon ();

   lab7bonus_top_sys dut (
      .CLOCK_50 (CLOCK_50),
      .KEY      (KEY),
      .SW       (SW),
      .LEDR     (LEDR),
      .HEX0     (HEX0),
      .HEX1     (HEX1),
      .HEX2     (HEX2),
      .HEX3     (HEX3),
      .HEX4     (HEX4),
      .HEX5     (HEX5)
   );

   assign mon.pc      = dut.bus.pc;
   assign mon.p0_ir   = dut.bus.p0_ir;
   assign mon.p1_ir   = dut.bus.p1_ir;
   assign mon.d_addr  = dut.bus.d_addr;
   assign mon.d_wdata = dut.bus.d_wdata;
   assign mon.d_rdata = dut.bus.d_rdata;
   assign mon.d_we    = dut.bus.d_we;

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(negedge CLOCK_50) if (dut.CPU.fetch_next === 1'b1) fn_count <= fn_count + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] e_movi(input int rn, input int im);
      return {3'b110, 2'b10, rn[2:0], im[7:0]};
   endfunction
   function automatic logic [15:0] e_movr(input int rd, input int rm, input int sh);
      return {3'b110, 2'b00, 3'b000, rd[2:0], sh[1:0], rm[2:0]};
   endfunction
   function automatic logic [15:0] e_alu(input int op, input int rn, input int rd, input int rm, input int sh);
      return {3'b101, op[1:0], rn[2:0], rd[2:0], sh[1:0], rm[2:0]};
   endfunction
   function automatic logic [15:0] e_ldr(input int rd, input int rn, input int im);
      return {3'b011, 2'b00, rn[2:0], rd[2:0], im[4:0]};
   endfunction
   function automatic logic [15:0] e_str(input int rd, input int rn, input int im);
      return {3'b100, 2'b00, rn[2:0], rd[2:0], im[4:0]};
   endfunction
   function automatic logic [15:0] e_b(input int cond, input int im);
      return {3'b001, 2'b00, cond[2:0], im[7:0]};
   endfunction
   function automatic logic [15:0] e_bl(input int im);
      return {3'b010, 2'b11, 3'b111, im[7:0]};
   endfunction
   function automatic logic [15:0] e_bx(input int rd);
      return {3'b010, 2'b00, 3'b000, rd[2:0], 5'b00000};
   endfunction
   function automatic logic [15:0] e_blx(input int rd);
      return {3'b010, 2'b10, 3'b111, rd[2:0], 5'b00000};
   endfunction
   localparam logic [15:0] I_HALT = 16'hE000;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic put(input int a, input logic [15:0] v);
      dut.mem[a] <= v;
   endtask

   task automatic hold_reset();
      @(negedge CLOCK_50);
      KEY[1] = 1'b0;
      for (int i = 0; i < 256; i++) dut.mem[i] <= 16'h0000;
   endtask

   task automatic release_reset();
      @(negedge CLOCK_50);
      KEY[1] = 1'b1;
      fn_base = fn_count;
   endtask

   task automatic wait_halt(input string tag, input int budget);
      int n = 0;
      while (dut.CPU.state !== S_HALT && n < budget) begin
         step(1);
         n++;
      end
      chk(tag, 64'(dut.CPU.state === S_HALT), 64'd1);
   endtask

   initial begin
      KEY = 4'hF;
      SW  = 10'h000;
      #5 KEY[1] = 1'b0;

      // reset state, then pairs MOV/MOV and STR/LDR, then ALU/shift ops
      hold_reset();
      put(0, e_movi(1, 2));
      put(1, e_movi(2, 0));
      put(2, e_str(1, 2, 12));
      put(3, e_ldr(3, 2, 12));
      put(4, e_movi(5, -3));
      put(5, e_alu(3, 0, 6, 5, 0));
      put(6, e_alu(0, 5, 7, 1, 1));
      put(7, e_alu(2, 5, 4, 5, 3));
      put(8, e_movr(0, 5, 2));
      put(9, I_HALT);
      @(negedge CLOCK_50);
      #1;
      chk("rst_pc", 64'(mon.pc), 64'd0);
      chk("rst_state", 64'(dut.CPU.state), 64'(S_FETCH));
      chk("rst_ledr", 64'(LEDR), 64'd0);
      chk("rst_r3", 64'(dut.CPU.regs[3]), 64'd0);
      chk("rst_flags", 64'({dut.CPU.flag_z, dut.CPU.flag_n, dut.CPU.flag_v}), 64'd0);
      chk("hex_off", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'h3FF_FFFF_FFFF);
      chk("p0_ir", 64'(mon.p0_ir), 64'(e_movi(1, 2)));
      chk("p1_ir", 64'(mon.p1_ir), 64'(e_movi(2, 0)));
      release_reset();
      step(3);
      chk("t1_r1", 64'(dut.CPU.regs[1]), 64'd2);
      chk("t1_r2", 64'(dut.CPU.regs[2]), 64'd0);
      chk("t1_fetch_next", 64'(fn_count - fn_base), 64'd1);
      chk("t1_pc", 64'(mon.pc), 64'd2);
      chk("t1_state", 64'(dut.CPU.state), 64'(S_FETCH));
      step(3);
      chk("t2_ram12", 64'(dut.mem[12]), 64'd2);
      chk("t2_r3", 64'(dut.CPU.regs[3]), 64'd2);
      wait_halt("t2_halt", 60);
      chk("alu_movi_sx", 64'(dut.CPU.regs[5]), 64'hFFFD);
      chk("alu_mvn", 64'(dut.CPU.regs[6]), 64'h0002);
      chk("alu_add_lsl", 64'(dut.CPU.regs[7]), 64'h0001);
      chk("alu_and_asr", 64'(dut.CPU.regs[4]), 64'hFFFC);
      chk("alu_mov_lsr", 64'(dut.CPU.regs[0]), 64'h7FFE);
      chk("alu_flags_kept", 64'(dut.CPU.flag_z), 64'd0);
      chk("t2_ledr_halt", 64'(LEDR), 64'h100);
      chk("t2_halt_pc", 64'(mon.pc), 64'd9);
      chk("t2_fetch_total", 64'(fn_count - fn_base), 64'd4);
      step(4);
      chk("halt_absorbing", 64'(dut.CPU.state), 64'(S_HALT));

      // switch read at 0x140 copied to LED at 0x100
      hold_reset();
      SW = 10'h35A;
      put(0, e_movi(0, 8'h40));
      put(1, e_movr(1, 0, 1));
      put(2, e_movr(2, 1, 1));
      put(3, e_alu(0, 2, 3, 0, 0));
      put(4, e_ldr(4, 3, 0));
      put(5, e_str(4, 2, 0));
      put(6, I_HALT);
      release_reset();
      wait_halt("t3_halt", 60);
      chk("t3_r3_addr", 64'(dut.CPU.regs[3]), 64'h0140);
      chk("t3_r4_sw", 64'(dut.CPU.regs[4]), 64'h005A);
      chk("t3_ledr", 64'(LEDR), 64'h15A);
      chk("t3_halt_pc", 64'(mon.pc), 64'd6);

      // conditional branches, cancelled p1, flags N/V
      hold_reset();
      put(0, e_movi(0, 5));
      put(1, e_alu(1, 0, 0, 0, 0));
      put(2, e_b(1, 2));
      put(3, e_movi(1, 8'h11));
      put(4, e_movi(2, 8'h22));
      put(5, e_b(2, 5));
      put(6, e_movi(3, 8'h33));
      put(7, e_movi(6, 7));
      put(8, e_alu(1, 0, 0, 6, 0));
      put(9, e_b(3, 3));
      put(10, e_movi(1, 8'h44));
      put(13, e_movi(4, -1));
      put(14, e_movr(4, 4, 2));
      put(15, e_movi(7, -1));
      put(16, e_alu(1, 4, 0, 7, 0));
      put(17, e_b(3, 1));
      put(18, I_HALT);
      release_reset();
      step(5);
      chk("beq_pc", 64'(mon.pc), 64'd5);
      chk("beq_z", 64'(dut.CPU.flag_z), 64'd1);
      chk("beq_fetch_next", 64'(fn_count - fn_base), 64'd2);
      step(3);
      chk("bne_fall_pc", 64'(mon.pc), 64'd7);
      chk("bne_fall_r3", 64'(dut.CPU.regs[3]), 64'h0033);
      step(5);
      chk("blt_pc", 64'(mon.pc), 64'd13);
      chk("blt_flags_zn_v", 64'({dut.CPU.flag_z, dut.CPU.flag_n, dut.CPU.flag_v}), 64'b010);
      wait_halt("t4_halt", 60);
      chk("cancel_r1", 64'(dut.CPU.regs[1]), 64'd0);
      chk("skip_r2", 64'(dut.CPU.regs[2]), 64'd0);
      chk("ovf_flags_zn_v", 64'({dut.CPU.flag_z, dut.CPU.flag_n, dut.CPU.flag_v}), 64'b011);
      chk("t4_r4_lsr", 64'(dut.CPU.regs[4]), 64'h7FFF);
      chk("t4_halt_pc", 64'(mon.pc), 64'd18);

      // BL / BX / BLX
      hold_reset();
      put(0, e_b(0, 15));
      put(1, e_movi(1, 8'h77));
      put(16, e_bl(4));
      put(17, e_movi(1, 8'h55));
      put(18, e_movi(2, 8'h20));
      put(19, e_blx(2));
      put(21, e_bx(7));
      put(32, I_HALT);
      release_reset();
      step(2);
      chk("b_pc", 64'(mon.pc), 64'h10);
      step(2);
      chk("bl_pc", 64'(mon.pc), 64'h15);
      chk("bl_r7", 64'(dut.CPU.regs[7]), 64'h11);
      step(2);
      chk("bx_pc", 64'(mon.pc), 64'h11);
      wait_halt("t5_halt", 60);
      chk("bx_r1", 64'(dut.CPU.regs[1]), 64'h55);
      chk("blx_r7", 64'(dut.CPU.regs[7]), 64'h14);
      chk("blx_pc", 64'(mon.pc), 64'h20);

      // asynchronous reset in the middle of EX0
      hold_reset();
      put(0, e_movi(1, 8'h3C));
      put(1, e_movi(2, 8'h40));
      put(2, e_movr(2, 2, 1));
      put(3, e_movr(2, 2, 1));
      put(4, e_str(1, 2, 0));
      put(5, e_movi(3, 1));
      put(6, e_b(0, -1));
      release_reset();
      for (int n = 0; n < 40 && LEDR[7:0] !== 8'h3C; n++) step(1);
      chk("t6_led_set", 64'(LEDR), 64'h03C);
      for (int n = 0; n < 4 && dut.CPU.state !== S_EX0; n++) step(1);
      chk("t6_in_ex0", 64'(dut.CPU.state), 64'(S_EX0));
      chk("t6_loop_pc", 64'(mon.pc), 64'd6);
      @(negedge CLOCK_50);
      KEY[1] = 1'b0;
      #1;
      chk("t6_async_pc", 64'(mon.pc), 64'd0);
      chk("t6_async_ledr", 64'(LEDR), 64'd0);
      chk("t6_async_state", 64'(dut.CPU.state), 64'(S_FETCH));
      chk("t6_async_r3", 64'(dut.CPU.regs[3]), 64'd0);
      chk("t6_ram_kept", 64'(dut.mem[5]), 64'(e_movi(3, 1)));
      release_reset();
      step(12);
      chk("t6_restart_ledr", 64'(LEDR), 64'h03C);
      chk("t6_restart_r3", 64'(dut.CPU.regs[3]), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
